// File: rtl/prelu_pkg.sv
// Shared encodings and Q-format constants for the PReLU streaming activation.
package prelu_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS    = 2'b00,
    MODE_RELU      = 2'b01,
    MODE_PRELU     = 2'b10,
    MODE_PRELU_ALT = 2'b11
  } mode_t;

  // Activations are Q8.8, slopes Q2.14.
  localparam int DATA_W_Q    = 16;
  localparam int COEF_W_Q    = 16;
  localparam int COEF_FRAC_Q = 14;

  // 0.25 in Q2.14
  localparam logic [15:0] SLOPE_DEFAULT = 16'h1000;

endpackage

// File: rtl/prelu_lane.sv
// One activation lane: negative-side scale by slope with round-half-up and saturation.
module prelu_lane
  import prelu_pkg::*;
#(
  parameter int DATA_W    = DATA_W_Q,
  parameter int COEF_W    = COEF_W_Q,
  parameter int COEF_FRAC = COEF_FRAC_Q
) (
  input  logic [DATA_W-1:0] x,
  input  logic [COEF_W-1:0] a,
  input  mode_t             mode,
  output logic [DATA_W-1:0] y,
  output logic              sat
);

  localparam int PW = DATA_W + COEF_W;
  localparam logic signed [PW-1:0] HALF = PW'(longint'(1) << (COEF_FRAC - 1));
  localparam logic signed [PW-1:0] MAXV = PW'((longint'(1) << (DATA_W - 1)) - 1);
  localparam logic signed [PW-1:0] MINV = ~MAXV;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rnd;
  logic signed [PW-1:0] shf;

  always_comb begin
    prod = $signed({{COEF_W{x[DATA_W-1]}}, x}) * $signed({{DATA_W{a[COEF_W-1]}}, a});
    rnd  = prod + HALF;
    shf  = rnd >>> COEF_FRAC;
    y    = x;
    sat  = 1'b0;
    if (x[DATA_W-1]) begin
      if (mode == MODE_RELU) begin
        y = '0;
      end else if (mode[1]) begin
        if (shf > MAXV) begin
          y   = MAXV[DATA_W-1:0];
          sat = 1'b1;
        end else if (shf < MINV) begin
          y   = MINV[DATA_W-1:0];
          sat = 1'b1;
        end else begin
          y = shf[DATA_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/prelu_stream.sv
// Two-stage streaming PReLU/ReLU/bypass with a per-channel slope table and
// a global stall enable shared by both stages.
module prelu_stream
  import prelu_pkg::*;
#(
  parameter int  DATA_W    = DATA_W_Q,
  parameter int  COEF_W    = COEF_W_Q,
  parameter int  COEF_FRAC = COEF_FRAC_Q,
  parameter int  LANES     = 8,
  parameter int  CHANNELS  = 64,
  localparam int CH_W      = $clog2(CHANNELS)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [1:0]              mode,
  input  logic                    coef_wr_en,
  input  logic [CH_W-1:0]         coef_wr_addr,
  input  logic [COEF_W-1:0]       coef_wr_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]         in_ch,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_last,
  output logic [15:0]             sat_cnt
);

  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);

  logic en;
  logic acc;
  logic wr_ok;
  logic rd_ok;
  logic [COEF_W-1:0] coef_rd;
  logic [COEF_W-1:0] coef_tab [CHANNELS];

  logic                           s1_vld;
  logic [LANES-1:0][DATA_W-1:0]   s1_x;
  logic                           s1_last;
  mode_t                          s1_mode;
  logic [COEF_W-1:0]              s1_coef;

  logic [LANES-1:0][DATA_W-1:0]   lane_y;
  logic [LANES-1:0]               lane_sat;
  logic [LANES-1:0]               s2_sat;
  logic [16:0]                    sat_add;
  logic [16:0]                    sat_sum;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst_in;
  assign acc      = in_valid && in_ready;
  assign wr_ok    = {1'b0, coef_wr_addr} < CH_LIM;
  assign rd_ok    = {1'b0, in_ch} < CH_LIM;
  // Combinational read sees the pre-write entry, so a same-cycle write lands one beat later.
  assign coef_rd  = rd_ok ? coef_tab[in_ch] : '0;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < CHANNELS; i++) coef_tab[i] <= COEF_W'(SLOPE_DEFAULT);
    end else if (coef_wr_en && wr_ok) begin
      coef_tab[coef_wr_addr] <= coef_wr_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_vld <= 1'b0;
    end else if (en) begin
      s1_vld <= acc;
      if (acc) begin
        s1_x    <= in_data;
        s1_last <= in_last;
        s1_mode <= mode_t'(mode);
        s1_coef <= coef_rd;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    prelu_lane #(
      .DATA_W    (DATA_W),
      .COEF_W    (COEF_W),
      .COEF_FRAC (COEF_FRAC)
    ) u_lane (
      .x    (s1_x[g]),
      .a    (s1_coef),
      .mode (s1_mode),
      .y    (lane_y[g]),
      .sat  (lane_sat[g])
    );
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      s2_sat    <= '0;
    end else if (en) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        out_data <= lane_y;
        out_last <= s1_last;
        s2_sat   <= lane_sat;
      end
    end
  end

  always_comb begin
    sat_add = '0;
    for (int i = 0; i < LANES; i++) sat_add = sat_add + 17'(s2_sat[i]);
    sat_sum = {1'b0, sat_cnt} + sat_add;
  end

  // Saturated lanes are counted as the beat is handed downstream.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

endmodule
